// File: rtl/dff_bank_pkg.sv
// dff_bank_pkg: op encodings and FSM state type shared by the DFF bank arbiter.
package dff_bank_pkg;
    localparam logic [1:0] OP_WR     = 2'b00;
    localparam logic [1:0] OP_CLRW   = 2'b01;
    localparam logic [1:0] OP_SETW   = 2'b10;
    localparam logic [1:0] OP_CLRALL = 2'b11;
    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible index at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         elig,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win,
    output logic                    valid
);
    logic found;
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[i] && i >= int'(ptr)) begin
                win[i] = 1'b1;
                found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && elig[i] && i < int'(ptr)) begin
                win[i] = 1'b1;
                found = 1'b1;
            end
        end
    end
    assign valid = |elig;
endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin shared DEPTH x WIDTH flop bank with word write/clear/set
// and a multi-cycle clear-all sweep that blocks other grants.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [AW*NREQ-1:0]      addr,
    input  logic [WIDTH*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [DEPTH*WIDTH-1:0]  q
);
    localparam int PW = $clog2(NREQ);
    logic [NREQ-1:0] elig, win, gnt_q, gnt_d;
    logic valid;
    logic [PW-1:0] rr_q, rr_d, owner_q, owner_d, w_idx;
    logic [AW-1:0] idx_q, idx_d, addr_w;
    logic [1:0] op_w;
    logic [WIDTH-1:0] wdata_w;
    logic [DEPTH-1:0][WIDTH-1:0] bank_q, bank_d;
    state_t state_q, state_d;
    // a requester still holding req in its grant cycle must not win again
    assign elig = req & ~gnt_q;
    rr_arbiter #(.NREQ(NREQ)) u_arb (.elig(elig), .ptr(rr_q), .win(win), .valid(valid));
    always_comb begin
        w_idx = '0;
        op_w = '0;
        addr_w = '0;
        wdata_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                w_idx = PW'(i);
                op_w = op[2*i +: 2];
                addr_w = addr[AW*i +: AW];
                wdata_w = wdata[WIDTH*i +: WIDTH];
            end
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        owner_d = owner_q;
        rr_d = rr_q;
        gnt_d = '0;
        bank_d = bank_q;
        if (state_q == ST_SWEEP) begin
            bank_d[idx_q] = '0;
            idx_d = (idx_q == AW'(DEPTH-1)) ? '0 : idx_q + 1'b1;
            if (idx_q == AW'(DEPTH-1)) begin
                gnt_d[owner_q] = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (valid) begin
            rr_d = (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            if (op_w == OP_CLRALL) begin
                state_d = ST_SWEEP;
                bank_d[0] = '0;
                idx_d = AW'(1);
                owner_d = w_idx;
            end else begin
                bank_d[addr_w] = (op_w == OP_WR) ? wdata_w : (op_w == OP_SETW) ? '1 : '0;
                gnt_d[w_idx] = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            idx_q <= '0;
            owner_q <= '0;
            rr_q <= '0;
            gnt_q <= '0;
            bank_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            gnt_q <= gnt_d;
            bank_q <= bank_d;
        end
    end
    assign gnt = gnt_q;
    assign busy = (state_q == ST_SWEEP);
    assign q = bank_q;
endmodule
